// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time,
// and presents {addr, inst} to IF/ID with a valid/ready handshake. Redirects
// from later stages replace the PC. A fetch already accepted by memory is
// marked for discard so that its stale response never reaches IF/ID.
module ifu_fetch #(
    parameter int unsigned           XLEN     = 64,
    parameter int unsigned           INST_LEN = 32,
    parameter logic [XLEN-1:0]       RESET_PC = 64'h0000_0000_8000_0000,
    parameter logic [INST_LEN-1:0]   INST_NOP = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [XLEN-1:0]     imem_req_addr,
    input  logic                imem_resp_valid,
    input  logic [INST_LEN-1:0] imem_resp_data,
    input  logic                imem_resp_err,
    output logic                o_valid,
    input  logic                o_ready,
    output logic [XLEN-1:0]     o_inst_addr,
    output logic [INST_LEN-1:0] o_inst_data,
    output logic                o_fault
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [1:0]          r_state;
    logic [XLEN-1:0]     r_pc;
    logic                r_drop;
    logic                r_req_valid;
    logic                r_valid;
    logic [XLEN-1:0]     r_inst_addr;
    logic [INST_LEN-1:0] r_inst_data;
    logic                r_fault;

    logic [1:0]          w_state_nxt;
    logic [XLEN-1:0]     w_pc_nxt;
    logic                w_drop_nxt;
    logic                w_capture;

    // Next-state, next-PC and discard-flag decode; redirect wins over all.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_drop_nxt  = r_drop;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
                if (redirect_valid) begin
                    w_pc_nxt = redirect_pc;
                end
            end
            S_REQ: begin
                if (redirect_valid) begin
                    w_pc_nxt = redirect_pc;
                end
                if (imem_req_ready) begin
                    // An accepted request under redirect is already stale.
                    w_state_nxt = S_WAIT;
                    w_drop_nxt  = redirect_valid;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    w_pc_nxt = redirect_pc;
                    if (imem_resp_valid) begin
                        // Outstanding response retires now; nothing left to drop.
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_drop_nxt = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (r_drop) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    w_pc_nxt    = redirect_pc;
                    w_state_nxt = S_REQ;
                end else if (o_ready) begin
                    w_pc_nxt    = r_pc + PC_STEP;
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, PC and registered outputs; responses outside WAIT are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_drop      <= 1'b0;
            r_req_valid <= 1'b0;
            r_valid     <= 1'b0;
            r_inst_addr <= '0;
            r_inst_data <= INST_NOP;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_drop      <= w_drop_nxt;
            r_req_valid <= (w_state_nxt == S_REQ);
            r_valid     <= (w_state_nxt == S_OUT);
            if (w_capture) begin
                r_inst_addr <= r_pc;
                r_inst_data <= imem_resp_err ? INST_NOP : imem_resp_data;
                r_fault     <= imem_resp_err;
            end
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_pc;
    assign o_valid        = r_valid;
    assign o_inst_addr    = r_inst_addr;
    assign o_inst_data    = r_inst_data;
    assign o_fault        = r_fault;

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch: a per-cycle vector table for the first fetches,
// then hand-written sequences for stalls, redirects, faults and reset.
// Every IF/ID transfer is checked against a scoreboard of expected entries.
module tb_ifu_fetch;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        o_valid;
    logic        o_ready;
    logic [63:0] o_inst_addr;
    logic [31:0] o_inst_data;
    logic        o_fault;

    ifu_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .o_valid         (o_valid),
        .o_ready         (o_ready),
        .o_inst_addr     (o_inst_addr),
        .o_inst_data     (o_inst_data),
        .o_fault         (o_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
        logic        fault;
    } sb_t;

    typedef struct {
        logic        rqr;
        logic        rsv;
        logic [31:0] rsd;
        logic        rse;
        logic        ordy;
        logic        keep;
        logic        e_rqv;
        logic [63:0] e_rqa;
        logic        e_ov;
        logic [63:0] e_oa;
        logic [31:0] e_od;
        logic        e_of;
    } vec_t;

    sb_t         sb[$];
    vec_t        vecs[13];
    int          checks;
    int          failures;
    int          cyc;
    int          last_hs;
    bit          have_last;
    bit          chk_spacing;
    logic [63:0] exp_pc;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock; at the falling edge, score any IF/ID transfer that will complete.
    task automatic tick();
        sb_t e;
        @(negedge clk);
        if (!rst && o_valid && o_ready && !redirect_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_transfer: got addr %0h with empty scoreboard", o_inst_addr);
            end else begin
                e = sb.pop_front();
                chk("xfer", 256'({o_inst_addr, o_inst_data, o_fault}), 256'({e.addr, e.data, e.fault}));
            end
            if (chk_spacing && have_last) chk("xfer_spacing", 256'(cyc - last_hs), 256'(3));
            last_hs   = cyc;
            have_last = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        chk("reset_state", 256'({o_valid, imem_req_valid, o_inst_addr, o_inst_data, o_fault}),
            256'({1'b0, 1'b0, 64'h0, NOP, 1'b0}));
        rst       = 1'b0;
        exp_pc    = RESET_PC;
        have_last = 1'b0;
    endtask

    // Complete fetch at exp_pc; consume=0 leaves the instruction parked in OUT.
    task automatic fetch(input logic [31:0] data, input logic err, input int lat,
                         input int stall, input bit consume);
        int          t;
        logic [31:0] ed;
        t  = 0;
        ed = err ? NOP : data;
        while (!imem_req_valid && t < 20) begin
            tick();
            t++;
        end
        chk("req", 256'({imem_req_valid, imem_req_addr}), 256'({1'b1, exp_pc}));
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        for (int i = 1; i < lat; i++) begin
            chk("wait_idle", 256'({o_valid, imem_req_valid}), 256'(2'b00));
            tick();
        end
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        imem_resp_err   = err;
        if (consume) sb.push_back('{exp_pc, ed, err});
        tick();
        imem_resp_valid = 1'b0;
        imem_resp_err   = 1'b0;
        chk("o_valid_latency", 256'(o_valid), 256'(1));
        if (consume) begin
            for (int i = 0; i < stall; i++) begin
                chk("stall_stable", 256'({o_valid, imem_req_valid, o_inst_addr, o_inst_data, o_fault}),
                    256'({1'b1, 1'b0, exp_pc, ed, err}));
                tick();
            end
            o_ready = 1'b1;
            tick();
            o_ready = 1'b0;
            exp_pc  = exp_pc + 64'd4;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; cyc = 0; last_hs = 0;
        have_last = 1'b0; chk_spacing = 1'b0;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        imem_resp_err = 1'b0; o_ready = 1'b0; exp_pc = RESET_PC;

        //            rqr rsv data          rse ordy keep | rqv addr                  ov o_addr                o_data        of
        vecs[0]  = '{0, 0, 32'h0,          0, 0, 0,  0, 64'h8000_0000, 0, 64'h0,          NOP,          0};
        vecs[1]  = '{1, 0, 32'h0,          0, 0, 0,  1, 64'h8000_0000, 0, 64'h0,          NOP,          0};
        vecs[2]  = '{0, 1, 32'h0010_0093,  0, 0, 1,  0, 64'h8000_0000, 0, 64'h0,          NOP,          0};
        vecs[3]  = '{0, 0, 32'h0,          0, 1, 0,  0, 64'h8000_0000, 1, 64'h8000_0000, 32'h0010_0093, 0};
        vecs[4]  = '{1, 0, 32'h0,          0, 0, 0,  1, 64'h8000_0004, 0, 64'h8000_0000, 32'h0010_0093, 0};
        vecs[5]  = '{0, 1, 32'h0020_0113,  0, 0, 1,  0, 64'h8000_0004, 0, 64'h8000_0000, 32'h0010_0093, 0};
        vecs[6]  = '{0, 0, 32'h0,          0, 0, 0,  0, 64'h8000_0004, 1, 64'h8000_0004, 32'h0020_0113, 0};
        vecs[7]  = '{0, 0, 32'h0,          0, 1, 0,  0, 64'h8000_0004, 1, 64'h8000_0004, 32'h0020_0113, 0};
        vecs[8]  = '{0, 0, 32'h0,          0, 0, 0,  1, 64'h8000_0008, 0, 64'h8000_0004, 32'h0020_0113, 0};
        vecs[9]  = '{1, 0, 32'h0,          0, 0, 0,  1, 64'h8000_0008, 0, 64'h8000_0004, 32'h0020_0113, 0};
        vecs[10] = '{0, 1, 32'hDEAD_BEEF,  1, 0, 1,  0, 64'h8000_0008, 0, 64'h8000_0004, 32'h0020_0113, 0};
        vecs[11] = '{0, 0, 32'h0,          0, 1, 0,  0, 64'h8000_0008, 1, 64'h8000_0008, NOP,          1};
        vecs[12] = '{0, 0, 32'h0,          0, 0, 0,  1, 64'h8000_000C, 0, 64'h8000_0008, NOP,          1};

        // Cycle-accurate table from reset release
        do_reset();
        for (int i = 0; i < 13; i++) begin
            imem_req_ready  = vecs[i].rqr;
            imem_resp_valid = vecs[i].rsv;
            imem_resp_data  = vecs[i].rsd;
            imem_resp_err   = vecs[i].rse;
            o_ready         = vecs[i].ordy;
            if (vecs[i].keep)
                sb.push_back('{vecs[i].e_rqa, vecs[i].rse ? NOP : vecs[i].rsd, vecs[i].rse});
            chk($sformatf("vec%0d", i),
                256'({imem_req_valid, imem_req_addr, o_valid, o_inst_addr, o_inst_data, o_fault}),
                256'({vecs[i].e_rqv, vecs[i].e_rqa, vecs[i].e_ov, vecs[i].e_oa, vecs[i].e_od, vecs[i].e_of}));
            tick();
        end
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_err = 1'b0; o_ready = 1'b0;

        // Straight-line fetches, one transfer every 3 cycles
        do_reset();
        chk_spacing = 1'b1;
        for (int i = 0; i < 4; i++) fetch(32'h0000_0093 + 32'(i << 7), 1'b0, 1, 0, 1'b1);
        chk_spacing = 1'b0;

        // IF/ID stall for 5 cycles, slow memory, then sequential PC
        fetch(32'h1234_5678, 1'b0, 1, 5, 1'b1);
        fetch(32'h0040_0193, 1'b0, 3, 0, 1'b1);

        // Redirect in WAIT; stale response arrives 3 cycles later and is dropped
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_1000; tick(); redirect_valid = 1'b0;
        tick(); tick();
        chk("wait_redirect_no_out", 256'(o_valid), 256'(0));
        imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD0_0001; tick(); imem_resp_valid = 1'b0;
        chk("wait_redirect_dropped", 256'({o_valid, imem_req_valid, imem_req_addr}), 256'({1'b0, 1'b1, 64'h8000_1000}));
        exp_pc = 64'h8000_1000;
        fetch(32'h0050_0213, 1'b0, 1, 0, 1'b1);

        // Response during OUT ignored; redirect in OUT with o_ready=1 is no transfer
        fetch(32'h0060_0293, 1'b0, 1, 0, 1'b0);
        imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD0_0002; tick(); imem_resp_valid = 1'b0;
        chk("out_resp_ignored", 256'({o_valid, o_inst_addr, o_inst_data}), 256'({1'b1, exp_pc, 32'h0060_0293}));
        redirect_valid = 1'b1; redirect_pc = 64'h8000_2000; o_ready = 1'b1; tick();
        redirect_valid = 1'b0; o_ready = 1'b0;
        chk("out_redirect", 256'({o_valid, imem_req_valid, imem_req_addr}), 256'({1'b0, 1'b1, 64'h8000_2000}));
        exp_pc = 64'h8000_2000;
        fetch(32'h0070_0313, 1'b0, 1, 0, 1'b1);

        // Redirect in the same cycle as the response
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD0_0003;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_3000; tick();
        imem_resp_valid = 1'b0; redirect_valid = 1'b0;
        chk("resp_redirect_same", 256'({o_valid, imem_req_valid, imem_req_addr}), 256'({1'b0, 1'b1, 64'h8000_3000}));
        exp_pc = 64'h8000_3000;
        fetch(32'h0080_0393, 1'b0, 1, 0, 1'b1);

        // Redirect while the request is being accepted
        imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_4000; tick();
        imem_req_ready = 1'b0; redirect_valid = 1'b0;
        chk("req_redirect_accept", 256'({o_valid, imem_req_valid}), 256'(2'b00));
        imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD0_0004; tick(); imem_resp_valid = 1'b0;
        chk("req_redirect_drop", 256'({o_valid, imem_req_valid, imem_req_addr}), 256'({1'b0, 1'b1, 64'h8000_4000}));
        exp_pc = 64'h8000_4000;
        fetch(32'h0090_0413, 1'b0, 1, 0, 1'b1);

        // Redirect in REQ without ready, then PC wraps past the top of memory
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; tick(); redirect_valid = 1'b0;
        chk("req_redirect_hold", 256'({imem_req_valid, imem_req_addr}), 256'({1'b1, 64'hFFFF_FFFF_FFFF_FFFC}));
        exp_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        fetch(32'h00A0_0493, 1'b0, 1, 0, 1'b1);
        chk("pc_wrap", 256'(exp_pc), 256'(64'h0));
        fetch(32'h00B0_0513, 1'b0, 1, 0, 1'b1);

        // Access fault, then reset in the middle of WAIT
        fetch(32'hFFFF_FFFF, 1'b1, 1, 2, 1'b1);
        imem_req_ready = 1'b1; tick(); imem_req_ready = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_wait_reset", 256'({o_valid, imem_req_valid, o_inst_addr, o_inst_data, o_fault}),
            256'({1'b0, 1'b0, 64'h0, NOP, 1'b0}));
        exp_pc = RESET_PC;
        chk("reset_pc", 256'(imem_req_addr), 256'(RESET_PC));
        fetch(32'h00C0_0593, 1'b0, 1, 0, 1'b1);

        tick();
        chk("scoreboard_empty", 256'(sb.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
